// File: rtl/iob_max_arbiter.sv
// -----------------------------------------------------------------------------
// iob_max_arbiter
//
// Round-robin arbiter and sequencer in front of a shared byte-maximum
// reduction datapath. One requester at a time is locked onto the datapath for
// a whole burst; the running maximum byte and beat count are returned together
// with the requester ID on a single response channel.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. Data is held stable by the sender while valid
// is high and ready is low. req_ready_o and resp_valid_o come from registered
// state only and never depend combinationally on req_* or resp_ready_i.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   clr_i         synchronous soft abort (returns to IDLE, keeps ptr)
//   req_valid_i   per-requester beat valid             [N_REQ]
//   req_last_i    per-requester last-beat marker       [N_REQ]
//   req_data_i    packed beat data, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o   per-requester beat accept, one-hot or zero
//   resp_valid_o  result available
//   resp_ready_i  result consumer accept
//   resp_id_o     requester that produced the result
//   resp_max_o    maximum byte over the burst
//   resp_cnt_o    number of beats in the burst, saturating
//   busy_o        high in any state other than IDLE
//   state_o       FSM state (0 IDLE, 1 BURST, 2 RESP) for observation
// -----------------------------------------------------------------------------
module iob_max_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ-1:0]          req_last_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [ID_W-1:0]           resp_id_o,
    output logic [7:0]                resp_max_o,
    output logic [CNT_W-1:0]          resp_cnt_o,
    output logic                      busy_o,
    output logic [1:0]                state_o
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    g_q;
    logic [7:0]         acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   req_ready_q;
    logic               resp_valid_q;
    logic               busy_q;

    // ------------------------------------------------------------------
    // Arbitration: rotate the valid vector so bit 0 corresponds to ptr,
    // pick the first set bit, then map back to an absolute index.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]   rot_valid;
    logic [ID_W-1:0]    pick;
    logic               any_valid;
    int                 pick_abs;
    logic               pick_found;

    assign rot_valid = N_REQ'({req_valid_i, req_valid_i} >> ptr_q);
    assign any_valid = |req_valid_i;

    always_comb begin
        pick_abs   = 0;
        pick_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && rot_valid[k]) begin
                pick_found = 1'b1;
                pick_abs   = int'(ptr_q) + k;
                if (pick_abs >= N_REQ) begin
                    pick_abs = pick_abs - N_REQ;
                end
            end
        end
        pick = ID_W'(pick_abs);
    end

    // ------------------------------------------------------------------
    // Granted-requester view: only the current owner's lines are looked at.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  gnt_data;
    logic               gnt_valid;
    logic               gnt_last;

    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == g_q) begin
                gnt_data  = req_data_i[i*DATA_W +: DATA_W];
                gnt_valid = req_valid_i[i];
                gnt_last  = req_last_i[i];
            end
        end
    end

    // Single-level byte maximum of the granted beat (unsigned).
    logic [7:0] beat_max;

    always_comb begin
        beat_max = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (gnt_data[b*8 +: 8] > beat_max) begin
                beat_max = gnt_data[b*8 +: 8];
            end
        end
    end

    logic               beat_fire;
    logic [7:0]         acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [ID_W-1:0]    ptr_d;

    assign beat_fire = (state_q == ST_BURST) && gnt_valid;
    assign acc_d     = (beat_max > acc_q) ? beat_max : acc_q;
    assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign ptr_d     = (g_q == ID_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;

    // ------------------------------------------------------------------
    // Sequencer. clr is checked before the state cases so it beats a
    // last beat or a response handshake in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            g_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (clr_i) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        state_q     <= ST_BURST;
                        g_q         <= pick;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        req_ready_q <= N_REQ'(1) << pick;
                        busy_q      <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (beat_fire) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (gnt_last) begin
                            state_q      <= ST_RESP;
                            req_ready_q  <= '0;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ptr_q        <= ptr_d;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= '0;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = g_q;
    assign resp_max_o   = acc_q;
    assign resp_cnt_o   = cnt_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_iob_max_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iob_max_arbiter
//
// Per-requester driver tasks stream planned bursts. A reference model walks
// the plans in round-robin order from a tracked pointer and pushes the
// expected {id, max, cnt} for every burst into exp_q; a monitor on the falling
// edge pops and compares on each response handshake, checks that the grant
// belongs to the burst at the head of the queue, and checks response fields
// stay stable under backpressure.
// -----------------------------------------------------------------------------
module tb_iob_max_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int RW  = IDW + 8 + CW;
    localparam int MAXB = 4;
    localparam int MAXL = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              clr;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        resp_max;
    logic [CW-1:0]     resp_cnt;
    logic              busy;
    logic [1:0]        state;

    iob_max_arbiter #(
        .N_REQ (N),
        .ID_W  (IDW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_id_o   (resp_id),
        .resp_max_o  (resp_max),
        .resp_cnt_o  (resp_cnt),
        .busy_o      (busy),
        .state_o     (state)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- burst plans and reference model ----------------
    int          nb[N];
    int          blen[N][MAXB];
    logic [31:0] bword[N][MAXB][MAXL];
    int          bstall_at[N][MAXB];
    int          bstall_len[N][MAXB];

    logic [RW-1:0] exp_q[$];
    int model_ptr = 0;

    function automatic int byte_max(input logic [31:0] w);
        int m = 0;
        for (int i = 0; i < 4; i++) begin
            if (int'(w[8*i +: 8]) > m) m = int'(w[8*i +: 8]);
        end
        return m;
    endfunction

    task automatic clear_plan();
        for (int r = 0; r < N; r++) begin
            nb[r] = 0;
            for (int b = 0; b < MAXB; b++) begin
                blen[r][b] = 0;
                bstall_at[r][b] = -1;
                bstall_len[r][b] = 0;
            end
        end
    endtask

    // Round-robin order: from the pointer, first requester with a burst left.
    task automatic build_expected();
        int rem[N];
        int nxt[N];
        int total = 0;
        for (int r = 0; r < N; r++) begin
            rem[r] = nb[r];
            nxt[r] = 0;
            total += nb[r];
        end
        while (total > 0) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (model_ptr + k) % N;
                if (rem[r] > 0) begin
                    int mx = 0;
                    int b;
                    int cnt;
                    b = nxt[r];
                    for (int j = 0; j < blen[r][b]; j++) begin
                        if (byte_max(bword[r][b][j]) > mx) mx = byte_max(bword[r][b][j]);
                    end
                    cnt = (blen[r][b] > 15) ? 15 : blen[r][b];
                    exp_q.push_back({IDW'(r), 8'(mx), CW'(cnt)});
                    model_ptr = (r + 1) % N;
                    rem[r]--;
                    nxt[r]++;
                    total--;
                    break;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int r);
        for (int b = 0; b < nb[r]; b++) begin
            for (int j = 0; j < blen[r][b]; j++) begin
                bit ok = 1'b0;
                req_data[r*DW +: DW] = bword[r][b][j];
                req_last[r]  = (j == blen[r][b] - 1);
                req_valid[r] = 1'b1;
                for (int c = 0; c < 3000 && !ok; c++) begin
                    @(negedge clk);
                    if (req_ready[r]) ok = 1'b1;
                end
                if (!ok) begin
                    timeout_fail("beat_accept");
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                if (bstall_len[r][b] > 0 && j == bstall_at[r][b] && j < blen[r][b] - 1) begin
                    req_valid[r] = 1'b0;
                    repeat (bstall_len[r][b]) @(posedge clk);
                    #1;
                end
            end
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    // resp_ready policy: 0 always high, 1 random, 2 low for 4 cycles per response, 3 low
    int rr_mode = 0;
    int rr_hold = 0;
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: resp_ready = 1'b1;
                1: resp_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (resp_valid) begin
                        if (rr_hold < 4) begin
                            resp_ready = 1'b0;
                            rr_hold++;
                        end else begin
                            resp_ready = 1'b1;
                        end
                    end else begin
                        rr_hold = 0;
                        resp_ready = 1'b1;
                    end
                end
                default: resp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    int phase = 0;
    int hs_prev = -1;
    int rise_cyc = -1;
    logic prev_rv = 1'b0;
    logic held_v = 1'b0;
    logic [RW-1:0] held_f;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (resp_valid && !prev_rv) rise_cyc = cyc;
                prev_rv = resp_valid;
                if (req_ready != '0) begin
                    chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
                    if (exp_q.size() > 0) begin
                        logic [RW-1:0] h;
                        h = exp_q[0];
                        chk("grant_owner", 64'(req_ready), 64'(N'(1) << h[RW-1 -: IDW]));
                    end
                end
                if (held_v && resp_valid) begin
                    chk("resp_stable", 64'({resp_id, resp_max, resp_cnt}), 64'(held_f));
                end
                held_v = resp_valid && !resp_ready;
                held_f = {resp_id, resp_max, resp_cnt};
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_resp");
                    end else begin
                        logic [RW-1:0] e;
                        e = exp_q.pop_front();
                        chk("resp_id",  64'(resp_id),  64'(e[RW-1 -: IDW]));
                        chk("resp_max", 64'(resp_max), 64'(e[CW +: 8]));
                        chk("resp_cnt", 64'(resp_cnt), 64'(e[CW-1:0]));
                    end
                    if (phase == 2) begin
                        if (hs_prev >= 0) chk("rr_spacing", 64'(cyc - hs_prev), 64'd3);
                        hs_prev = cyc;
                    end
                end
            end else begin
                prev_rv = 1'b0;
                held_v  = 1'b0;
            end
        end
    end

    int phase_c0 = 0;

    task automatic run_phase();
        build_expected();
        @(posedge clk);
        #1;
        phase_c0 = cyc;
        fork
            drive(0);
            drive(1);
            drive(2);
            drive(3);
        join
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            timeout_fail("responses_drained");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({req_ready, resp_valid, resp_id, resp_max, resp_cnt, busy, state}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single burst from requester 1, latency and return to idle
        phase = 1;
        clear_plan();
        nb[1] = 1;
        blen[1][0] = 2;
        bword[1][0][0] = 32'h01020304;
        bword[1][0][1] = 32'h0A00FF05;
        run_phase();
        chk("first_resp_latency", 64'(rise_cyc - phase_c0), 64'd3);
        chk("busy_after_resp", 64'(busy), 64'd0);
        chk("idle_after_resp", 64'(state), 64'd0);

        // Stall of requester 2 with requester 3 waiting, response backpressure
        phase = 3;
        rr_mode = 2;
        clear_plan();
        nb[2] = 1;
        blen[2][0] = 3;
        bword[2][0][0] = 32'h10203040;
        bword[2][0][1] = 32'h00000099;
        bword[2][0][2] = 32'h7F000001;
        bstall_at[2][0] = 0;
        bstall_len[2][0] = 5;
        nb[3] = 1;
        blen[3][0] = 1;
        bword[3][0][0] = 32'h00C00000;
        run_phase();
        rr_mode = 0;

        // Round robin with all requesters holding one-beat bursts
        phase = 2;
        hs_prev = -1;
        clear_plan();
        for (int r = 0; r < N; r++) begin
            nb[r] = 2;
            for (int b = 0; b < 2; b++) begin
                blen[r][b] = 1;
                bword[r][b][0] = 32'h11 * (r + 1);
            end
        end
        run_phase();
        phase = 4;

        // Count saturation and all-ones bytes
        clear_plan();
        nb[0] = 1;
        blen[0][0] = 20;
        for (int j = 0; j < 20; j++) bword[0][0][j] = 32'h00000000;
        nb[1] = 1;
        blen[1][0] = 3;
        for (int j = 0; j < 3; j++) bword[1][0][j] = 32'hFFFFFFFF;
        run_phase();

        // clr together with an accepted last beat
        begin
            bit ok = 1'b0;
            @(posedge clk);
            #1;
            req_data[2*DW +: DW] = 32'h000000AA;
            req_last[2] = 1'b0;
            req_valid[2] = 1'b1;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                if (req_ready[2]) ok = 1'b1;
            end
            if (!ok) timeout_fail("clr_grant");
            @(posedge clk);
            #1;
            req_data[2*DW +: DW] = 32'h000000BB;
            req_last[2] = 1'b1;
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            req_valid[2] = 1'b0;
            req_last[2] = 1'b0;
            @(negedge clk);
            chk("clr_no_resp", 64'(resp_valid), 64'd0);
            chk("clr_state_idle", 64'(state), 64'd0);
            chk("clr_busy", 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
            chk("clr_no_resp_later", 64'(resp_valid), 64'd0);
        end
        // Pointer must be untouched by the aborted burst
        clear_plan();
        for (int r = 0; r < N; r++) begin
            nb[r] = 1;
            blen[r][0] = 1;
            bword[r][0][0] = $urandom;
        end
        run_phase();

        // Randomized bursts with stalls and random backpressure
        rr_mode = 1;
        for (int rep = 0; rep < 4; rep++) begin
            clear_plan();
            for (int r = 0; r < N; r++) begin
                nb[r] = $urandom_range(0, 3);
                for (int b = 0; b < nb[r]; b++) begin
                    blen[r][b] = $urandom_range(1, 6);
                    for (int j = 0; j < blen[r][b]; j++) begin
                        bword[r][b][j] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
                    end
                    if ($urandom_range(0, 2) == 0) begin
                        bstall_at[r][b] = $urandom_range(0, 5);
                        bstall_len[r][b] = $urandom_range(1, 4);
                    end
                end
            end
            run_phase();
        end
        rr_mode = 0;

        // Asynchronous reset while a response is pending
        rr_mode = 3;
        begin
            bit ok = 1'b0;
            @(posedge clk);
            #1;
            req_data[0 +: DW] = 32'h12345678;
            req_last[0] = 1'b1;
            req_valid[0] = 1'b1;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                if (req_ready[0]) ok = 1'b1;
            end
            if (!ok) timeout_fail("rst_grant");
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            req_last[0] = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                if (resp_valid) ok = 1'b1;
            end
            if (!ok) timeout_fail("rst_resp_wait");
            chk("pre_rst_id", 64'(resp_id), 64'd0);
            chk("pre_rst_max", 64'(resp_max), 64'h78);
            chk("pre_rst_cnt", 64'(resp_cnt), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk_all_zero("async_reset_outputs");
            @(negedge clk);
            rst_n = 1'b1;
        end
        rr_mode = 0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 64'({resp_valid, busy, state}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_max_arbiter.md
# iob_max_arbiter

Round-robin arbiter and sequencer that shares one byte-maximum reduction datapath among N_REQ requesters. Each requester streams a burst of 32-bit words over a valid/ready handshake. The block locks the datapath to one requester for the whole burst and accumulates the running maximum of all bytes seen. It then returns the result, the beat count and the requester ID on a single response channel. It sits between the CPU-facing register peripherals and the max-reduction logic, replacing per-peripheral copies of that logic.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, ≥ clog2(N_REQ)
- DATA_W, 32, word width, a multiple of 8
- CNT_W, 16, beat counter width
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low; one clock domain
- clr  input  1  synchronous soft abort, active-high
- req_valid  input  N_REQ  per-requester beat valid
- req_last  input  N_REQ  marks the final beat of a burst
- req_data  input  N_REQ*DATA_W  beat data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  per-requester beat accept; one-hot or zero
- resp_valid  output  1  result available
- resp_ready  input  1  result consumer accept
- resp_id  output  ID_W  requester that produced the result
- resp_max  output  8  maximum byte over the burst
- resp_cnt  output  CNT_W  beats in the burst, saturating
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BURST, RESP.
- IDLE:
  - If any req_valid is high, the block grants the lowest index at or above ptr that has valid high, wrapping modulo N_REQ.
  - The grant is registered in g, acc is set to 0, cnt is set to 0, and the FSM moves to BURST.
  - req_ready is all zero in IDLE.
- BURST:
  - req_ready[g] = 1 and all other bits are 0.
  - A beat is accepted when req_valid[g] and req_ready[g] are both high.
  - On each accepted beat: acc ← max(acc, max over the DATA_W/8 bytes of the beat), unsigned compare; cnt ← cnt+1, saturating at 2^CNT_W−1.
  - An accepted beat with req_last[g] high moves the FSM to RESP.
  - If req_valid[g] drops mid-burst, the block stalls with the grant held. Other requesters stay blocked.
- RESP:
  - resp_valid = 1. resp_id = g, resp_max = acc and resp_cnt = cnt, all held stable until the handshake completes.
  - On resp_ready: ptr ← (g+1) mod N_REQ, and the FSM returns to IDLE.
- clr:
  - Moves the FSM to IDLE from any state and drops acc, cnt and g. ptr is unchanged.
  - clr wins over a simultaneous last beat or resp handshake: no response is produced and no beat is counted.
- The byte-max of a beat is combinational, single level. Inputs from requesters that are not granted are ignored.

## Timing
- Reset (rst low): FSM = IDLE, ptr = 0, g = 0, acc = 0, cnt = 0.
- Outputs in reset: req_ready = 0, resp_valid = 0, resp_id = 0, resp_max = 0, resp_cnt = 0, busy = 0.
- Reset asserted mid-burst or mid-response takes effect immediately, asynchronously. The partial burst is lost.
- Arbitration takes 1 cycle. If valid is first seen in IDLE at cycle t, req_ready[g] rises at t+1.
- With valid held, a k-beat burst is accepted in cycles t+1..t+k and resp_valid rises at t+k+1.
- With resp_ready held high, the next arbitration happens at t+k+2. A burst of k beats occupies k+2 cycles.
- All outputs are registered-state driven. There is no combinational path from req_* or resp_ready to req_ready or resp_valid within the same cycle.

## Test plan
- Single burst: requester 1 sends 0x01020304 then 0x0A00FF05 (last), resp_ready=1.
  - Required: resp_valid at cycle 3 after valid, resp_id=1, resp_max=0xFF, resp_cnt=2, then busy=0.
- Round-robin: all 4 requesters hold 1-beat bursts, with values 0x11, 0x22, 0x33, 0x44 in byte 0.
  - Required: responses in ID order 0,1,2,3, then 0 again. Each response is 3 cycles apart.
- Stall and backpressure: requester 2 drops valid for 5 cycles mid-burst, and resp_ready is held low for 4 cycles.
  - Required: the grant stays on 2 during the gap, and requester 3 gets no req_ready.
  - Required: resp fields stay stable during the backpressure, and the result is correct.
- Saturation and edge values: CNT_W=4, 20 beats of 0x00000000.
  - Required: resp_cnt=15, resp_max=0x00.
  - Separately, a burst of all 0xFFFFFFFF beats must give resp_max=0xFF.
- clr and reset: clr asserted on the same cycle as an accepted last beat.
  - Required: no resp_valid, FSM back in IDLE, ptr unchanged.
  - Separately, rst pulsed low in RESP must clear every output to 0 asynchronously.
